// File: rtl/instr_loader.sv
// Program loader: receives a little-endian length header and instruction words
// over a byte stream and writes them into instruction memory one word at a time.
module instr_loader #(
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        io_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] addr_io,
  output logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IDXW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     word_q, word_d;
  // One extra bit so idx can reach N == MAX_WORDS after the final write.
  logic [IDXW:0]   idx_q, idx_d;
  logic [1:0]      bcnt_q, bcnt_d;

  logic            accept;
  logic            last_byte;
  logic            restart;
  logic [31:0]     len_shift;
  logic [31:0]     idx_next;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = accept && (bcnt_q == 2'd3);
  assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  // Bytes shift in from the top, so the first byte ends up in [7:0].
  assign len_shift = {rx_data, len_q[31:8]};
  assign idx_next  = 32'(idx_q) + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (len_shift == 32'd0)                 state_d = S_DONE;
          else if (len_shift > 32'(MAX_WORDS))    state_d = S_ERR;
          else                                    state_d = S_DATA;
        end
      end
      S_DATA:  if (last_byte) state_d = S_WRITE;
      S_WRITE: state_d = (idx_next == len_q) ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
    busy     = rx_ready || (state_q == S_WRITE);
    io_sel   = busy;
    mem_we   = (state_q == S_WRITE);
    mem_en   = mem_we;
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
  end

  always_comb begin
    len_d  = len_q;
    word_d = word_q;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    if (restart) begin
      len_d  = '0;
      idx_d  = '0;
      bcnt_d = '0;
    end else if (state_q == S_LEN && accept) begin
      len_d  = len_shift;
      bcnt_d = bcnt_q + 2'd1;
    end else if (state_q == S_DATA && accept) begin
      word_d = {rx_data, word_q[31:8]};
      bcnt_d = bcnt_q + 2'd1;
    end else if (state_q == S_WRITE) begin
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      word_q <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
    end else begin
      len_q  <= len_d;
      word_q <= word_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign addr_io = {{(30 - IDXW){1'b0}}, idx_q[IDXW-1:0], 2'b00};
  assign din     = word_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter MAX_WORDS, default 4096, is the instruction memory depth in 32-bit words.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a program load.
REQ-005 rx_data  input  8  received byte from the serial receiver.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 io_sel  output  1  drives the instruction memory address mux: 1 selects the loader address, 0 selects the processor address.
REQ-009 mem_en  output  1  instruction memory enable during loader writes.
REQ-010 mem_we  output  1  instruction memory write enable.
REQ-011 addr_io  output  32  byte address of the write, word-aligned.
REQ-012 din  output  32  write data word.
REQ-013 busy  output  1  a load is in progress.
REQ-014 done  output  1  a load completed successfully; the processor may run.
REQ-015 err  output  1  the header length exceeded MAX_WORDS.

Function
REQ-016 A byte SHALL be accepted only in a cycle where rx_valid=1 and rx_ready=1.
REQ-017 The FSM SHALL have states IDLE, LEN, DATA, WRITE, DONE and ERR.
REQ-018 In IDLE, a start pulse SHALL move the FSM to LEN and clear the word index, byte counter, done and err.
REQ-019 In LEN, the FSM SHALL accept 4 bytes, little-endian, into a 32-bit length N.
REQ-020 On the 4th LEN byte, the next state SHALL be DONE if N=0, ERR if N>MAX_WORDS, and DATA otherwise.
REQ-021 In DATA, the FSM SHALL accept 4 bytes, little-endian, into a word register.
REQ-022 On the 4th DATA byte, the next state SHALL be WRITE.
REQ-023 WRITE SHALL last exactly one cycle with mem_we=1, mem_en=1, addr_io={idx,2'b00} and din equal to the assembled word.
REQ-024 After WRITE, idx SHALL increment, and the next state SHALL be DONE if idx+1==N, otherwise DATA.
REQ-025 rx_ready SHALL be 1 only in LEN and DATA, and SHALL be 0 in WRITE, so no byte is dropped or duplicated.
REQ-026 io_sel and busy SHALL be 1 in LEN, DATA and WRITE, and 0 in IDLE, DONE and ERR.
REQ-027 mem_we and mem_en SHALL be 1 only in WRITE.
REQ-028 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-029 A start pulse in DONE or ERR SHALL restart the load exactly as from IDLE.
REQ-030 A start pulse in LEN, DATA or WRITE SHALL be ignored.
REQ-031 Latency from the 4th byte of a word to mem_we=1 SHALL be exactly 1 cycle.
REQ-032 A byte presented while rx_valid=1 and the FSM is not in LEN or DATA SHALL be held by the sender, not consumed.
REQ-033 addr_io[31:2+log2(MAX_WORDS)] SHALL always be 0, and addr_io[1:0] SHALL always be 0.
REQ-034 idx SHALL never exceed N-1 when mem_we=1.

Reset
REQ-035 When rst=1, the FSM SHALL enter IDLE on the next clock edge, including in the middle of a load.
REQ-036 On reset, rx_ready, io_sel, mem_en, mem_we, busy, done and err SHALL be 0; addr_io, din, idx, N and the byte counter SHALL be 0.
REQ-037 A partially written program SHALL NOT be marked done after reset.

Verification
REQ-038 start; bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes addr 0x0 data 0x12345678 and addr 0x4 data 0xDEADBEEF, then done=1 and io_sel=0.
REQ-039 start; length bytes 00 00 00 00 -> no mem_we pulse; done=1 one cycle after the 4th byte.
REQ-040 start; length 0x00001001 with MAX_WORDS=4096 -> err=1, no write, rx_ready=0.
REQ-041 rx_valid held at 1 continuously through a 3-word load -> rx_ready=0 on each WRITE cycle; exactly 3 writes with correct, non-duplicated data.
REQ-042 rst asserted after 2 of 3 words are written -> all outputs 0 and done=0; a new start then loads correctly from addr 0.
REQ-043 start pulse during DATA -> ignored; the load completes with unchanged N.
